// File: rtl/cellrv32_uart_tx.sv
// UART transmit engine: pops words from an upstream FIFO and serialises start/data/[parity]/stop.
// Optional even-parity bit is compiled in only when CELLRV32_UART_TX_PARITY_EN is defined.
module cellrv32_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PRSC_W    = 12
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 en_i,
    input  logic [PRSC_W-1:0]    baud_div_i,
    input  logic                 parity_en_i,
    input  logic                 fifo_avail_i,
    input  logic [DATA_BITS-1:0] fifo_rdata_i,
    output logic                 fifo_re_o,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef CELLRV32_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [PRSC_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [PRSC_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;
    logic                 pop;
    logic                 bit_end;

`ifdef CELLRV32_UART_TX_PARITY_EN
    logic par_q, par_d;
    logic par_en_q, par_en_d;
`else
    logic unused_parity_en;
    assign unused_parity_en = parity_en_i;
`endif

    assign bit_end = (baud_cnt_q == div_q);

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + PRSC_W'(1);
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        pop        = 1'b0;
`ifdef CELLRV32_UART_TX_PARITY_EN
        par_d      = par_q;
        par_en_d   = par_en_q;
`endif

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                txd_d      = 1'b1;
                if (en_i && fifo_avail_i) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata_i;
                    div_d   = baud_div_i;
                    txd_d   = 1'b0;
                    state_d = S_START;
`ifdef CELLRV32_UART_TX_PARITY_EN
                    par_d    = ^fifo_rdata_i;
                    par_en_d = parity_en_i;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef CELLRV32_UART_TX_PARITY_EN
                        if (par_en_q) begin
                            txd_d   = par_q;
                            state_d = S_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = S_STOP;
                        end
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
`ifdef CELLRV32_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Disabling the engine drops the current word and returns the line to idle.
        if (!en_i) begin
            state_d    = S_IDLE;
            txd_d      = 1'b1;
            done_d     = 1'b0;
            pop        = 1'b0;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
`ifdef CELLRV32_UART_TX_PARITY_EN
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
`ifdef CELLRV32_UART_TX_PARITY_EN
            par_q      <= par_d;
            par_en_q   <= par_en_d;
`endif
        end
    end

    // NOTE: the data shift register carries no reset; it is always reloaded at pop before use.
    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
    end

    assign fifo_re_o = pop && rstn_i;
    assign txd_o     = txd_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;

endmodule
